// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_pkg
//  Brief    : Op codes, FSM state codes and default latencies for the HI/LO
//             multiply/divide sequencer.
//  Revision : 1.0
// ============================================================================
package md_pkg;

    localparam logic [2:0] HOP_NONE  = 3'd0;
    localparam logic [2:0] HOP_MULT  = 3'd1;
    localparam logic [2:0] HOP_MULTU = 3'd2;
    localparam logic [2:0] HOP_DIV   = 3'd3;
    localparam logic [2:0] HOP_DIVU  = 3'd4;
    localparam logic [2:0] HOP_MTHI  = 3'd5;
    localparam logic [2:0] HOP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int DEF_CNT_W       = 4;

endpackage
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
//  Module   : md_arith
//  Brief    : Combinational signed/unsigned 32x32 multiply and divide.
//  Revision : 1.0
// ============================================================================
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi_res,
    output logic [31:0] o_lo_res,
    output logic        o_div0
);

    logic        w_signed;
    logic        w_is_div;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;
    logic [31:0] w_q;
    logic [31:0] w_r;

    always_comb begin
        w_signed = (i_op == HOP_MULT) || (i_op == HOP_DIV);
        w_is_div = (i_op == HOP_DIV)  || (i_op == HOP_DIVU);

        // Sign-extended operands make a plain 64-bit product correct for both flavours.
        w_ext_a = {{32{w_signed & i_a[31]}}, i_a};
        w_ext_b = {{32{w_signed & i_b[31]}}, i_b};
        w_prod  = w_ext_a * w_ext_b;

        // Divide on magnitudes; 0x80000000 stays 0x80000000 as an unsigned magnitude.
        w_mag_a = (w_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
        w_mag_b = (w_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
        o_div0  = w_is_div && (i_b == 32'd0);
        if (w_mag_b == 32'd0) begin
            w_mag_q = 32'd0;
            w_mag_r = 32'd0;
        end else begin
            w_mag_q = w_mag_a / w_mag_b;
            w_mag_r = w_mag_a % w_mag_b;
        end
        w_q = (w_signed && (i_a[31] ^ i_b[31])) ? (32'd0 - w_mag_q) : w_mag_q;
        w_r = (w_signed && i_a[31])             ? (32'd0 - w_mag_r) : w_mag_r;

        if (w_is_div) begin
            o_hi_res = w_r;
            o_lo_res = w_q;
        end else begin
            o_hi_res = w_prod[63:32];
            o_lo_res = w_prod[31:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
//  Module   : md_sched
//  Brief    : HI/LO multiply/divide sequencer: owns HI/LO, runs a fixed busy
//             window per op and drives the D-stage HI/LO stall.
//  Revision : 1.0
// ============================================================================
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  hilo_op_e,
    input  logic [31:0] src_a_e,
    input  logic [31:0] src_b_e,
    input  logic        is_hilo_d,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;

    logic               w_is_md;
    logic               w_is_div;
    logic               w_div0;
    logic [CNT_W-1:0]   w_lat;
    logic [31:0]        w_hi_res;
    logic [31:0]        w_lo_res;

    md_arith u_arith (
        .i_op     (hilo_op_e),
        .i_a      (src_a_e),
        .i_b      (src_b_e),
        .o_hi_res (w_hi_res),
        .o_lo_res (w_lo_res),
        .o_div0   (w_div0)
    );

    always_comb begin
        w_is_md  = (hilo_op_e >= HOP_MULT) && (hilo_op_e <= HOP_DIVU);
        w_is_div = (hilo_op_e == HOP_DIV)  || (hilo_op_e == HOP_DIVU);
        w_lat    = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        start    = (r_state == S_IDLE) && w_is_md;
        stall_md = is_hilo_d & (start | r_busy);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (w_is_md) begin
                // A divide by zero re-commits the current HI/LO; nothing can write them while busy.
                r_pend_hi <= w_div0 ? r_hi : w_hi_res;
                r_pend_lo <= w_div0 ? r_lo : w_lo_res;
                r_cnt     <= w_lat;
                r_busy    <= 1'b1;
                r_state   <= S_BUSY;
            end else if (hilo_op_e == HOP_MTHI) begin
                r_hi <= src_a_e;
            end else if (hilo_op_e == HOP_MTLO) begin
                r_lo <= src_a_e;
            end
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_hi    <= r_pend_hi;
                r_lo    <= r_pend_lo;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_sched
//  Brief    : Self-checking bench for md_sched against an arithmetic reference.
//  Revision : 1.0
// ============================================================================
module tb_md_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  hilo_op_e;
    logic [31:0] src_a_e;
    logic [31:0] src_b_e;
    logic        is_hilo_d;
    logic        start;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    int busy_seen;

    // Reference: cycles of busy remaining and the result due at the end.
    int          m_rem;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .hilo_op_e (hilo_op_e),
        .src_a_e   (src_a_e),
        .src_b_e   (src_b_e),
        .is_hilo_d (is_hilo_d),
        .start     (start),
        .busy      (busy),
        .stall_md  (stall_md),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] ohi,
                                               input logic [31:0] olo);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin q = sa * sb; return q; end
            3'd2: begin uq = ua * ub; return uq; end
            3'd3: begin
                if (b == 0) return {ohi, olo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 0) return {ohi, olo};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return {ohi, olo};
        endcase
    endfunction

    function automatic bit is_md(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    task automatic check_cycle();
        logic exp_start;
        exp_start = (m_rem == 0) && is_md(hilo_op_e);
        chk("start", {31'd0, start}, {31'd0, exp_start});
        chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
        chk("stall_md", {31'd0, stall_md}, {31'd0, is_hilo_d & (exp_start | (m_rem > 0))});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (busy) busy_seen++;
    endtask

    task automatic model_edge();
        logic [63:0] res;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (is_md(hilo_op_e)) begin
            res   = ref_result(hilo_op_e, src_a_e, src_b_e, m_hi, m_lo);
            m_phi = res[63:32];
            m_plo = res[31:0];
            m_rem = (hilo_op_e >= 3'd3) ? DC : MC;
        end else if (hilo_op_e == 3'd5) begin
            m_hi = src_a_e;
        end else if (hilo_op_e == 3'd6) begin
            m_lo = src_a_e;
        end
    endtask

    // Called at posedge+1; leaves time at the next posedge+1.
    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic hd);
        hilo_op_e = op;
        src_a_e   = a;
        src_b_e   = b;
        is_hilo_d = hd;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic hd, input int exp_len);
        int guard;
        busy_seen = 0;
        guard = 0;
        step(op, a, b, hd);
        while (m_rem > 0 && guard < 50) begin
            step(3'd0, 32'd0, 32'd0, hd);
            guard++;
        end
        step(3'd0, 32'd0, 32'd0, hd);
        chk("busy_len", busy_seen, exp_len);
    endtask

    initial begin
        reset     = 1'b1;
        hilo_op_e = 3'd0;
        src_a_e   = 32'd0;
        src_b_e   = 32'd0;
        is_hilo_d = 1'b0;
        m_rem = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(3'd2, 32'h3, 32'hFFFF_FFFE, 1'b0, MC);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        run_op(3'd1, 32'h3, 32'hFFFF_FFFE, 1'b0, MC);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        run_op(3'd4, 32'd100, 32'd7, 1'b1, DC);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, DC);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DC);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0);

        step(3'd5, 32'h1234, 32'd0, 1'b0);
        step(3'd6, 32'h5678, 32'd0, 1'b0);
        step(3'd0, 32'd0, 32'd0, 1'b0);
        chk("mthi", hi, 32'h1234);
        chk("mtlo", lo, 32'h5678);
        run_op(3'd3, 32'd77, 32'd0, 1'b0, DC);
        chk("div0_hi", hi, 32'h1234);
        chk("div0_lo", lo, 32'h5678);

        // Asynchronous reset in the third busy cycle of a divide.
        step(3'd3, 32'd1000, 32'd3, 1'b0);
        step(3'd0, 32'd0, 32'd0, 1'b0);
        step(3'd0, 32'd0, 32'd0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        #1;
        reset = 1'b0;
        m_rem = 0; m_hi = 0; m_lo = 0;
        @(posedge clk); #1;
        run_op(3'd1, 32'd2, 32'd3, 1'b0, MC);
        chk("post_rst_lo", lo, 32'd6);
        chk("post_rst_hi", hi, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            step(op, a, b, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
